// File: rtl/pc_next_unit.sv
// pc_next_unit: IF-stage program-counter register with an N-source next-PC
// select. Holds the PC under stall, buffers one redirect that arrives while
// stalled (newest wins), and flags misaligned fetch addresses.
//
// Optional feature macro: PC_NEXT_EXC_VEC_EN
//   When defined, adds exc_req/epc. An exception request takes precedence over
//   stall and redirect, loads EXC_VECTOR and saves the current pc in epc.
module pc_next_unit #(
    parameter int               WIDTH    = 32,
    parameter int               NSRC     = 4,
    parameter int               SEL_W    = 2,
    parameter int               INC      = 4,
    parameter logic [WIDTH-1:0] RESET_PC = 'h0000_3000
`ifdef PC_NEXT_EXC_VEC_EN
    ,
    parameter logic [WIDTH-1:0] EXC_VECTOR = 'h0000_4180
`endif
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  redirect_valid,
    input  logic [SEL_W-1:0]      redirect_sel,
    input  logic [NSRC*WIDTH-1:0] src_in,
`ifdef PC_NEXT_EXC_VEC_EN
    input  logic                  exc_req,
    output logic [WIDTH-1:0]      epc,
`endif
    output logic [WIDTH-1:0]      pc,
    output logic [WIDTH-1:0]      pc_plus,
    output logic                  pend_valid,
    output logic                  misalign
);

    logic [WIDTH-1:0] tgt;
    logic [WIDTH-1:0] pend_target;
    logic [WIDTH-1:0] pc_d;
    logic [WIDTH-1:0] pend_target_d;
    logic             pend_valid_d;

    // Sequential fall-through address, wraps modulo 2^WIDTH.
    assign pc_plus = pc + WIDTH'(INC);

    // Redirect target mux; an out-of-range select falls back to source 0.
    always_comb begin
        // NOTE: default assignment first so every path drives tgt (no latch).
        tgt = src_in[0 +: WIDTH];
        for (int k = 1; k < NSRC; k++) begin
            if (redirect_sel == SEL_W'(k)) begin
                tgt = src_in[k*WIDTH +: WIDTH];
            end
        end
    end

    // Next-state priority: exception, stall(+buffer), live redirect, pending, increment.
    always_comb begin
        pc_d          = pc;
        pend_target_d = pend_target;
        pend_valid_d  = pend_valid;
`ifdef PC_NEXT_EXC_VEC_EN
        if (exc_req) begin
            pc_d         = EXC_VECTOR;
            pend_valid_d = 1'b0;
        end else
`endif
        if (stall) begin
            if (redirect_valid) begin
                pend_target_d = tgt;
                pend_valid_d  = 1'b1;
            end
        end else if (redirect_valid) begin
            pc_d         = tgt;
            pend_valid_d = 1'b0;
        end else if (pend_valid) begin
            pc_d         = pend_target;
            pend_valid_d = 1'b0;
        end else begin
            pc_d = pc_plus;
        end
    end

    // PC, pending-redirect buffer and misalign flag registers.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (reset) begin
            pc          <= RESET_PC;
            pend_valid  <= 1'b0;
            pend_target <= '0;
            misalign    <= (RESET_PC[1:0] != 2'b00);
        end else begin
            pc          <= pc_d;
            pend_valid  <= pend_valid_d;
            pend_target <= pend_target_d;
            misalign    <= (pc_d[1:0] != 2'b00);
        end
    end

`ifdef PC_NEXT_EXC_VEC_EN
    // Exception return address: captured on exception entry, held otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            epc <= '0;
        end else if (exc_req) begin
            epc <= pc;
        end
    end
`endif

endmodule
